// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: widths, opcodes,
// the queued command record and the issue FSM states.
package alu_pkg;

   localparam int ALU_DW  = 8;
   localparam int ALU_OPW = 4;
   localparam int ALU_TW  = 4;

   localparam logic [ALU_OPW-1:0] ALU_ADD = 4'd0;
   localparam logic [ALU_OPW-1:0] ALU_SUB = 4'd1;
   localparam logic [ALU_OPW-1:0] ALU_AND = 4'd2;
   localparam logic [ALU_OPW-1:0] ALU_OR  = 4'd3;
   localparam logic [ALU_OPW-1:0] ALU_XOR = 4'd4;

   typedef struct packed {
      logic [ALU_TW-1:0]  tag;
      logic [ALU_OPW-1:0] op;
      logic [ALU_DW-1:0]  a;
      logic [ALU_DW-1:0]  b;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of issue commands; head entry is visible combinationally
// on rd_data whenever the FIFO is non-empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   input  alu_cmd_t wr_data,
   output alu_cmd_t rd_data,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   alu_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU: queues commands, drives the
// ALU one command at a time and returns tagged results in order.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DW    = ALU_DW,
   parameter int OPW   = ALU_OPW,
   parameter int DEPTH = 4,
   parameter int TW    = ALU_TW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [DW-1:0]  cmd_a,
   input  logic [DW-1:0]  cmd_b,
   input  logic [OPW-1:0] cmd_op,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_opcode,
   input  logic [DW-1:0]  alu_result,
   input  logic           alu_zero,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [DW-1:0]  rsp_result,
   output logic           rsp_zero,
   output logic [TW-1:0]  rsp_tag,
   output logic           busy
);

   issue_state_e  state;
   alu_cmd_t      wr_data;
   alu_cmd_t      head;
   logic          full;
   logic          empty;
   logic          pop;
   logic [TW-1:0] tag_ctr;
   logic [TW-1:0] cur_tag;

   assign cmd_ready = !full;
   assign wr_data   = '{tag: tag_ctr, op: cmd_op, a: cmd_a, b: cmd_b};
   assign pop       = !empty && ((state == IDLE) || (state == RESP && rsp_ready));
   assign busy      = !empty || (state != IDLE);

   alu_cmd_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (cmd_valid),
      .pop    (pop),
      .wr_data(wr_data),
      .rd_data(head),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_ctr <= '0;
      end else if (cmd_valid && cmd_ready) begin
         tag_ctr <= tag_ctr + 1'b1;
      end
   end

   // A handshake in RESP may chain straight into the next EXEC when work is queued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         cur_tag    <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_tag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  alu_a      <= head.a;
                  alu_b      <= head.b;
                  alu_opcode <= head.op;
                  cur_tag    <= head.tag;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_tag    <= cur_tag;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (!empty) begin
                     alu_a      <= head.a;
                     alu_b      <= head.b;
                     alu_opcode <= head.op;
                     cur_tag    <= head.tag;
                     state      <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU
// hooked onto the alu_* ports.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] cmd_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_opcode;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_zero;
   logic [3:0] rsp_tag;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_op    (cmd_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_opcode(alu_opcode),
      .alu_result(alu_result),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_result(rsp_result),
      .rsp_zero  (rsp_zero),
      .rsp_tag   (rsp_tag),
      .busy      (busy)
   );

   function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = aluModel(alu_a, alu_b, alu_opcode);
   assign alu_zero   = (alu_result == 8'h00);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   // Test 4 vectors with hand-computed ALU results
   logic [7:0] bp_a   [6] = '{8'h80, 8'h10, 8'hF0, 8'h0F, 8'hFF, 8'h01};
   logic [7:0] bp_b   [6] = '{8'h80, 8'h20, 8'h3C, 8'h30, 8'h0F, 8'h01};
   logic [3:0] bp_op  [6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_ADD};
   logic [7:0] bp_res [5] = '{8'h00, 8'hF0, 8'h30, 8'h3F, 8'hF0};
   logic       bp_zf  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      int accepted;
      int cyc;
      int sent;
      int got;
      int last_cyc;
      logic push_now;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_op    = 4'h0;
      rsp_ready = 1'b1;

      $display("[TB] test 1: reset");
      repeat (2) tick();
      checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'h1);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("reset_busy",      32'(busy),      32'h0);
      checkOutput("reset_alu_a",     32'(alu_a),     32'h0);
      checkOutput("reset_rsp_tag",   32'(rsp_tag),   32'h0);
      rst_n = 1'b1;
      tick();

      $display("[TB] test 2: single command");
      applyStimulus(8'h0F, 8'h01, ALU_ADD);
      tick();
      cmd_valid = 1'b0;
      checkOutput("single_busy",        32'(busy),      32'h1);
      checkOutput("single_valid_early", 32'(rsp_valid), 32'h0);
      tick();
      checkOutput("single_alu_a",       32'(alu_a),      32'h0F);
      checkOutput("single_alu_op",      32'(alu_opcode), 32'(ALU_ADD));
      checkOutput("single_valid_k1",    32'(rsp_valid),  32'h0);
      tick();
      checkOutput("single_rsp_valid",   32'(rsp_valid),  32'h1);
      checkOutput("single_rsp_result",  32'(rsp_result), 32'h10);
      checkOutput("single_rsp_zero",    32'(rsp_zero),   32'h0);
      checkOutput("single_rsp_tag",     32'(rsp_tag),    32'h0);
      tick();
      checkOutput("single_done_valid",  32'(rsp_valid),  32'h0);
      checkOutput("single_done_busy",   32'(busy),       32'h0);

      $display("[TB] test 3: zero flag");
      applyStimulus(8'h05, 8'h05, ALU_SUB);
      tick();
      cmd_valid = 1'b0;
      repeat (2) tick();
      checkOutput("zero_rsp_valid",  32'(rsp_valid),  32'h1);
      checkOutput("zero_rsp_result", 32'(rsp_result), 32'h00);
      checkOutput("zero_rsp_zero",   32'(rsp_zero),   32'h1);
      checkOutput("zero_rsp_tag",    32'(rsp_tag),    32'h1);
      tick();

      $display("[TB] test 4: backpressure and full");
      doReset();
      tick();
      rsp_ready = 1'b0;
      accepted  = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(bp_a[i], bp_b[i], bp_op[i]);
         checkOutput($sformatf("bp_ready_%0d", i), 32'(cmd_ready), (i < 5) ? 32'h1 : 32'h0);
         if (cmd_ready) accepted++;
         tick();
      end
      cmd_valid = 1'b0;
      checkOutput("bp_accepted",    32'(accepted),   32'd5);
      checkOutput("bp_ready_after", 32'(cmd_ready),  32'h0);
      checkOutput("bp_hold_valid",  32'(rsp_valid),  32'h1);
      checkOutput("bp_hold_result", 32'(rsp_result), 32'h00);
      checkOutput("bp_hold_tag",    32'(rsp_tag),    32'h0);
      repeat (3) tick();
      checkOutput("bp_stable_valid",  32'(rsp_valid),  32'h1);
      checkOutput("bp_stable_result", 32'(rsp_result), 32'h00);
      checkOutput("bp_stable_zero",   32'(rsp_zero),   32'h1);
      checkOutput("bp_stable_tag",    32'(rsp_tag),    32'h0);
      checkOutput("bp_stable_ready",  32'(cmd_ready),  32'h0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc = 0;
         while (!rsp_valid && cyc < 10) begin
            tick();
            cyc++;
         end
         checkOutput($sformatf("bp_rsp_valid_%0d", i),  32'(rsp_valid),  32'h1);
         checkOutput($sformatf("bp_rsp_tag_%0d", i),    32'(rsp_tag),    32'(i));
         checkOutput($sformatf("bp_rsp_result_%0d", i), 32'(rsp_result), 32'(bp_res[i]));
         checkOutput($sformatf("bp_rsp_zero_%0d", i),   32'(rsp_zero),   32'(bp_zf[i]));
         tick();
      end
      tick();
      checkOutput("bp_drained_busy", 32'(busy), 32'h0);

      $display("[TB] test 5: tag wrap streaming");
      doReset();
      tick();
      rsp_ready = 1'b1;
      sent      = 0;
      got       = 0;
      cyc       = 0;
      last_cyc  = 0;
      while ((sent < 18 || got < 18) && cyc < 200) begin
         if (sent < 18) applyStimulus(sent[7:0], 8'h10, ALU_ADD);
         else cmd_valid = 1'b0;
         if (rsp_valid) begin
            checkOutput($sformatf("wrap_tag_%0d", got),    32'(rsp_tag),    32'(got % 16));
            checkOutput($sformatf("wrap_result_%0d", got), 32'(rsp_result), 32'(got + 16));
            if (got > 0)
               checkOutput($sformatf("wrap_gap_%0d", got), 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            got++;
         end
         push_now = cmd_valid && cmd_ready;
         tick();
         cyc++;
         if (push_now) sent++;
      end
      cmd_valid = 1'b0;
      checkOutput("wrap_sent", 32'(sent), 32'd18);
      checkOutput("wrap_got",  32'(got),  32'd18);
      repeat (2) tick();

      $display("[TB] test 6: reset mid-operation");
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h11 + 8'(i), 8'h01, ALU_ADD);
         tick();
      end
      cmd_valid = 1'b0;
      checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("mid_busy",      32'(busy),      32'h1);
      checkOutput("mid_alu_a",     32'(alu_a),     32'h11);
      rst_n = 1'b0;
      tick();
      checkOutput("mid_rst_valid",  32'(rsp_valid),  32'h0);
      checkOutput("mid_rst_busy",   32'(busy),       32'h0);
      checkOutput("mid_rst_ready",  32'(cmd_ready),  32'h1);
      checkOutput("mid_rst_alu_a",  32'(alu_a),      32'h0);
      checkOutput("mid_rst_result", 32'(rsp_result), 32'h0);
      checkOutput("mid_rst_tag",    32'(rsp_tag),    32'h0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("mid_quiet_%0d", i), 32'(rsp_valid), 32'h0);
      end
      applyStimulus(8'h03, 8'h04, ALU_ADD);
      tick();
      cmd_valid = 1'b0;
      repeat (2) tick();
      checkOutput("mid_next_valid",  32'(rsp_valid),  32'h1);
      checkOutput("mid_next_tag",    32'(rsp_tag),    32'h0);
      checkOutput("mid_next_result", 32'(rsp_result), 32'h07);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
